// File: rtl/vot_prag_seq.sv
// Debounced N-input voter: popcount-based decision rule, edge pulses and a saturating event counter.
// Optional macro VOT_FALL_EVT_EN adds a match_fall pulse that is counted alongside match_rise.
module vot_prag_seq #(
  parameter int N_IN       = 4,
  parameter int DEB_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_IN-1:0]              in_vec,
  input  logic [1:0]                   mode,
  input  logic [$clog2(N_IN+1)-1:0]    thr,
  input  logic                         clr,
  output logic [N_IN-1:0]              stable_vec,
  output logic [$clog2(N_IN+1)-1:0]    pop_cnt,
  output logic                         match,
  output logic                         match_rise,
  output logic [CNT_W-1:0]             evt_cnt,
  output logic                         evt_ovf
`ifdef VOT_FALL_EVT_EN
  ,
  output logic                         match_fall
`endif
);

  localparam int POP_W = $clog2(N_IN + 1);
  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_THR   = 2'd0,
    MODE_ALL   = 2'd1,
    MODE_ANY   = 2'd2,
    MODE_EXACT = 2'd3
  } mode_e;

  logic [N_IN-1:0]  stable_q, stable_d;
  logic [3:0]       deb_q [N_IN];
  logic [3:0]       deb_d [N_IN];
  logic [POP_W-1:0] pop_sum;
  logic             match_q, match_d;
  logic             match_dly_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             evt;
`ifdef VOT_FALL_EVT_EN
  logic             fall_q, fall_d;
`endif

  // Each channel counts consecutive disagreeing samples; a disagreement run of
  // DEB_CYCLES accepts the new level, any agreeing sample discards the run.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      deb_d[i] = 4'd0;
      if (in_vec[i] != stable_q[i]) begin
        if (deb_q[i] == DEB_LAST) stable_d[i] = in_vec[i];
        else                      deb_d[i]    = deb_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < N_IN; i++) pop_sum = pop_sum + POP_W'(stable_q[i]);
  end

  always_comb begin
    match_d = 1'b0;
    case (mode_e'(mode))
      MODE_THR:   match_d = (pop_sum >= thr);
      MODE_ALL:   match_d = (pop_sum == POP_W'(N_IN));
      MODE_ANY:   match_d = (pop_sum != '0);
      MODE_EXACT: match_d = (pop_sum == thr);
      default:    match_d = 1'b0;
    endcase
  end

  always_comb begin
    rise_d = match_q & ~match_dly_q;
`ifdef VOT_FALL_EVT_EN
    fall_d = ~match_q & match_dly_q;
    evt    = rise_q | fall_q;
`else
    evt    = rise_q;
`endif
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // clr has priority, so an event landing on the same edge is dropped.
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (evt) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q    <= '0;
      // NOTE: the debounce counter array is reset too; a stale count would shorten the first debounce.
      for (int i = 0; i < N_IN; i++) deb_q[i] <= 4'd0;
      match_q     <= 1'b0;
      match_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
`ifdef VOT_FALL_EVT_EN
      fall_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      stable_q    <= stable_d;
      for (int i = 0; i < N_IN; i++) deb_q[i] <= deb_d[i];
      match_q     <= match_d;
      match_dly_q <= match_q;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
`ifdef VOT_FALL_EVT_EN
      fall_q      <= fall_d;
`endif
    end
  end

  assign stable_vec = stable_q;
  assign pop_cnt    = pop_sum;
  assign match      = match_q;
  assign match_rise = rise_q;
  assign evt_cnt    = cnt_q;
  assign evt_ovf    = ovf_q;
`ifdef VOT_FALL_EVT_EN
  assign match_fall = fall_q;
`endif

endmodule

// File: doc/vot_prag_seq.md
Name: vot_prag_seq

Overview:
- Parametrised sequential successor to the 4-input/3-output combinational family-logic decoder.
- Takes N_IN raw person/condition inputs and debounces each channel.
- Computes the population count of the stable inputs and evaluates a runtime-selectable decision rule (threshold, all, any, exact).
- Registers the decision, emits rising-edge pulses and keeps a saturating event counter; used as the decision stage of lab exercises.

Parameters:
- N_IN, 4: number of input channels, 2..16.
- DEB_CYCLES, 2: consecutive cycles a changed input must hold before it is accepted, 1..15.
- CNT_W, 8: event counter width, 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_vec  input  N_IN  raw channel inputs
- mode  input  2  0=threshold (pop>=thr), 1=all, 2=any, 3=exact (pop==thr)
- thr  input  $clog2(N_IN+1)  threshold for modes 0 and 3
- clr  input  1  synchronous clear of evt_cnt/evt_ovf
- stable_vec  output  N_IN  debounced inputs (registered)
- pop_cnt  output  $clog2(N_IN+1)  ones count of stable_vec (combinational from stable_vec)
- match  output  1  registered decision
- match_rise  output  1  one-cycle pulse on match 0->1
- evt_cnt  output  CNT_W  saturating count of match_rise pulses
- evt_ovf  output  1  sticky: increment requested while evt_cnt at max

Behaviour:
- Reset: rst_n=0 immediately clears stable_vec, all debounce counters, match, match_rise, evt_cnt and evt_ovf to 0, including mid-operation. First evaluation happens on the first edge after deassertion.
- Debounce, per channel i, with counter deb_i:
  - If in_vec[i]!=stable_vec[i] and deb_i==DEB_CYCLES-1: stable_vec[i]<=in_vec[i], deb_i<=0.
  - Else if they differ: deb_i<=deb_i+1.
  - Else: deb_i<=0. A glitch shorter than DEB_CYCLES cycles resets the count and is discarded.
- Debounce latency: an input change present before edge k appears on stable_vec after edge k+DEB_CYCLES-1. DEB_CYCLES=1 gives a plain 1-cycle register.
- pop_cnt: full-width popcount of stable_vec; no overflow is possible.
- match is registered one edge after stable_vec, computed from the current pop_cnt and current mode/thr:
  - Mode 0: pop>=thr. thr=0 gives always 1; thr>N_IN gives always 0.
  - Mode 1: pop==N_IN.
  - Mode 2: pop!=0.
  - Mode 3: pop==thr.
- A mode/thr change takes effect on the next edge, like any input change; it is not debounced.
- match_rise is registered: 1 for exactly one cycle on the edge after match goes 0->1.
  - Following a reset with thr=0 in mode 0, match=1 after the first edge and match_rise pulses after the second edge.
- evt_cnt, evaluated on each edge:
  - If clr=1: evt_cnt<=0, evt_ovf<=0. clr wins over a simultaneous match_rise, whose event is lost.
  - Else if match_rise and evt_cnt==2^CNT_W-1: evt_cnt holds and evt_ovf<=1.
  - Else if match_rise: evt_cnt<=evt_cnt+1.
- evt_ovf stays set until clr or reset. evt_cnt never wraps.

Optional Feature:
- Macro: VOT_FALL_EVT_EN.
- Defined:
  - Adds output port match_fall (1 bit), a one-cycle registered pulse on match 1->0, same timing as match_rise.
  - evt_cnt increments on match_rise OR match_fall. Both edges cannot pulse in the same cycle.
  - Saturation, ovf and clr rules are unchanged.
- Undefined: no match_fall port; only rising edges are counted.

Test Plan:
1. Reset:
   - Drive mode=0, thr=1, in_vec=4'b1111 until evt_cnt=1, then pulse rst_n=0 between edges.
   - Expect all outputs 0 immediately, without waiting for a clock edge.
   - After release, expect stable_vec=1111 two edges later and evt_cnt to count again from 0.
2. Glitch reject (DEB_CYCLES=2):
   - in_vec 0000 -> 0001 for 1 cycle -> 0000.
   - Expect stable_vec=0000 throughout, match=0, evt_cnt=0.
3. Threshold:
   - mode=0, thr=3, in_vec 0000->1011 held.
   - Expect stable_vec=1011 at edge k+1, pop_cnt=3, match=1 at k+2, match_rise=1 only at k+3, then evt_cnt=1.
4. Exact/all/any:
   - mode=3, thr=2, in_vec=0011 -> match=1. Change to 0111 -> match=0, evt_cnt unchanged.
   - mode=1 with 1111 -> match=1. mode=2 with 0000 -> match=0.
5. Saturation, CNT_W=2:
   - Generate 4 rising events -> evt_cnt=3, evt_ovf=1.
   - clr=1 for one edge -> evt_cnt=0, evt_ovf=0.
   - clr coincident with match_rise -> evt_cnt=0.
6. VOT_FALL_EVT_EN defined:
   - Toggle match 0->1->0.
   - Expect one match_rise pulse, one match_fall pulse, and evt_cnt=2.
